// File: rtl/lfsr_test_ctrl.sv
// Test sequencer for the 8-bit LFSR generator/checker pair: seeds both blocks, measures lock
// latency, verifies lock holds for a run, and optionally injects corruption to prove lock drops.
module lfsr_test_ctrl #(
   parameter int unsigned LOCK_TIMEOUT = 32,
   parameter int unsigned RUN_CYCLES   = 64,
   parameter int unsigned INJECT_LEN   = 4
) (
   input  logic       clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [7:0] i_seed,
   input  logic       i_inject_en,
   input  logic       i_lock,
   output logic       o_valid,
   output logic       o_soft_reset,
   output logic [7:0] o_seed,
   output logic       o_corrupt,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_pass,
   output logic [1:0] o_fail_code,
   output logic [7:0] o_lock_latency
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_ACQ,
      ST_RUN,
      ST_INJECT,
      ST_DROP,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      FC_PASS        = 2'd0,
      FC_ACQ_TIMEOUT = 2'd1,
      FC_LOCK_LOST   = 2'd2,
      FC_NO_DROP     = 2'd3
   } fail_code_t;

   localparam logic [7:0]  TIMER_LAST = 8'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] RUN_LAST   = 16'(RUN_CYCLES - 1);
   localparam logic [3:0]  INJ_LAST   = 4'(INJECT_LEN - 1);

   state_t     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [15:0] run_cnt_q, run_cnt_d;
   logic [3:0] inj_cnt_q, inj_cnt_d;
   logic       inject_en_q, inject_en_d;
   logic       dropped_q, dropped_d;

   logic       valid_q, valid_d;
   logic       soft_reset_q, soft_reset_d;
   logic [7:0] seed_q, seed_d;
   logic       corrupt_q, corrupt_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   fail_code_t fail_code_q, fail_code_d;
   logic [7:0] latency_q, latency_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      timer_d     = timer_q;
      run_cnt_d   = run_cnt_q;
      inj_cnt_d   = inj_cnt_q;
      inject_en_d = inject_en_q;
      dropped_d   = dropped_q;
      seed_d      = seed_q;
      pass_d      = pass_q;
      fail_code_d = fail_code_q;
      latency_d   = latency_q;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               seed_d      = i_seed;
               inject_en_d = i_inject_en;
               pass_d      = 1'b0;
               fail_code_d = FC_PASS;
               latency_d   = 8'd0;
               state_d     = ST_SEED;
            end
         end

         ST_SEED: begin
            timer_d   = 8'd0;
            dropped_d = 1'b0;
            state_d   = ST_ACQ;
         end

         ST_ACQ: begin
            if (i_lock) begin
               latency_d = timer_q;
               run_cnt_d = 16'd0;
               state_d   = ST_RUN;
            end else if (timer_q == TIMER_LAST) begin
               fail_code_d = FC_ACQ_TIMEOUT;
               state_d     = ST_DONE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end

         ST_RUN: begin
            // A lost lock wins over run completion in the same cycle.
            if (!i_lock) begin
               fail_code_d = FC_LOCK_LOST;
               state_d     = ST_DONE;
            end else if (run_cnt_q == RUN_LAST) begin
               if (inject_en_q) begin
                  inj_cnt_d = 4'd0;
                  state_d   = ST_INJECT;
               end else begin
                  pass_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end else begin
               run_cnt_d = run_cnt_q + 16'd1;
            end
         end

         ST_INJECT: begin
            if (!i_lock) begin
               dropped_d = 1'b1;
            end
            if (inj_cnt_q == INJ_LAST) begin
               timer_d = 8'd0;
               state_d = ST_DROP;
            end else begin
               inj_cnt_d = inj_cnt_q + 4'd1;
            end
         end

         ST_DROP: begin
            dropped_d = dropped_q | ~i_lock;
            if (dropped_q || !i_lock) begin
               pass_d  = 1'b1;
               state_d = ST_DONE;
            end else if (timer_q == TIMER_LAST) begin
               fail_code_d = FC_NO_DROP;
               state_d     = ST_DONE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Strobes are decoded from the next state so the registered copies line up with it.
      valid_d      = (state_d == ST_ACQ) || (state_d == ST_RUN) ||
                     (state_d == ST_INJECT) || (state_d == ST_DROP);
      soft_reset_d = (state_d == ST_SEED);
      corrupt_d    = (state_d == ST_INJECT);
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         timer_q      <= 8'd0;
         run_cnt_q    <= 16'd0;
         inj_cnt_q    <= 4'd0;
         inject_en_q  <= 1'b0;
         dropped_q    <= 1'b0;
         valid_q      <= 1'b0;
         soft_reset_q <= 1'b0;
         seed_q       <= 8'd0;
         corrupt_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_code_q  <= FC_PASS;
         latency_q    <= 8'd0;
      end else begin
         // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
         state_q      <= state_d;
         timer_q      <= timer_d;
         run_cnt_q    <= run_cnt_d;
         inj_cnt_q    <= inj_cnt_d;
         inject_en_q  <= inject_en_d;
         dropped_q    <= dropped_d;
         valid_q      <= valid_d;
         soft_reset_q <= soft_reset_d;
         seed_q       <= seed_d;
         corrupt_q    <= corrupt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         fail_code_q  <= fail_code_d;
         latency_q    <= latency_d;
      end
   end

   assign o_valid        = valid_q;
   assign o_soft_reset   = soft_reset_q;
   assign o_seed         = seed_q;
   assign o_corrupt      = corrupt_q;
   assign o_busy         = busy_q;
   assign o_done         = done_q;
   assign o_pass         = pass_q;
   assign o_fail_code    = fail_code_q;
   assign o_lock_latency = latency_q;

endmodule
